// File: rtl/sorter_pkg.sv
// Shared constants and FSM encoding for the sorter result bus and its readers.
package sorter_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned COUNT = 8;
    localparam int unsigned IDX_W = $clog2(COUNT);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/sort_order_check.sv
// Flags a frame whose ranks are not non-decreasing (unsigned compare, ties allowed).
module sort_order_check #(
    parameter int unsigned WIDTH = sorter_pkg::WIDTH,
    parameter int unsigned COUNT = sorter_pkg::COUNT
) (
    input  logic [COUNT-1:0][WIDTH-1:0] vals,
    output logic                        err_c
);

    always_comb begin
        err_c = 1'b0;
        for (int unsigned i = 0; i + 1 < COUNT; i++) begin
            if (vals[i] > vals[i+1]) err_c = 1'b1;
        end
    end

endmodule

// File: rtl/sorted_streamer.sv
// Snapshots the sorter result bus on each done rise and streams it over valid/ready
// in ascending or descending rank order.
module sorted_streamer #(
    parameter int unsigned WIDTH = sorter_pkg::WIDTH,
    parameter int unsigned COUNT = sorter_pkg::COUNT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          done,
    input  logic [WIDTH-1:0]              LT,
    input  logic [WIDTH-1:0]              LO,
    input  logic [WIDTH-1:0]              LM,
    input  logic [WIDTH-1:0]              ME,
    input  logic [WIDTH-1:0]              MH,
    input  logic [WIDTH-1:0]              HI,
    input  logic [WIDTH-1:0]              HR,
    input  logic [WIDTH-1:0]              HT,
    input  logic                          order,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [sorter_pkg::IDX_W-1:0]  out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic                          sort_err,
    output logic                          overrun
);

    import sorter_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

    state_t                      state;
    logic                        done_q;
    logic                        order_q;
    logic [IDX_W-1:0]            cnt;
    logic [COUNT-1:0][WIDTH-1:0] frame_q;

    logic                        rise;
    logic                        streaming;
    logic                        last_beat;
    logic                        capture;
    logic                        frame_err_c;
    logic [IDX_W-1:0]            idx_c;
    logic [COUNT-1:0][WIDTH-1:0] bus_c;

    // Element 0 is rank 0 (LT).
    assign bus_c = {HT, HR, HI, MH, ME, LM, LO, LT};

    sort_order_check #(
        .WIDTH (WIDTH),
        .COUNT (COUNT)
    ) u_check (
        .vals  (bus_c),
        .err_c (frame_err_c)
    );

    assign rise      = done & ~done_q;
    assign streaming = (state == STREAM);
    assign last_beat = streaming && out_ready && (cnt == LAST);
    // A rise coinciding with the final accepted beat chains straight into the next frame.
    assign capture   = rise && (!streaming || last_beat);
    assign idx_c     = order_q ? (LAST - cnt) : cnt;

    assign out_valid = streaming;
    assign busy      = streaming;
    assign out_index = streaming ? idx_c : '0;
    assign out_data  = streaming ? frame_q[idx_c] : '0;
    assign out_last  = streaming && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done_q   <= 1'b1;
            order_q  <= 1'b0;
            cnt      <= '0;
            frame_q  <= '0;
            sort_err <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done_q <= done;
            if (capture) begin
                frame_q  <= bus_c;
                order_q  <= order;
                sort_err <= frame_err_c;
                cnt      <= '0;
                state    <= STREAM;
            end else if (streaming && out_ready) begin
                if (cnt == LAST) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + IDX_W'(1);
                end
            end
            if (rise && streaming && !last_beat) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sorted_streamer.sv
// Randomized self-checking bench for sorted_streamer against a frame-level reference model.
module tb_sorted_streamer;

    typedef logic [3:0] frame_t [8];
    typedef struct packed {
        logic [3:0] data;
        logic [2:0] idx;
        logic       last;
    } beat_t;
    typedef beat_t beat_q_t [$];

    logic       clk = 1'b0;
    logic       rst, done, order, out_ready;
    logic [3:0] LT, LO, LM, ME, MH, HI, HR, HT;
    logic       out_valid, out_last, busy, sort_err, overrun;
    logic [3:0] out_data;
    logic [2:0] out_index;

    int checks = 0;
    int errors = 0;

    sorted_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .LT        (LT),
        .LO        (LO),
        .LM        (LM),
        .ME        (ME),
        .MH        (MH),
        .HI        (HI),
        .HR        (HR),
        .HT        (HT),
        .order     (order),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .sort_err  (sort_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Expected beat sequence: ranks in ascending or descending order, last on the 8th beat.
    function automatic beat_q_t model_frame(input frame_t v, input logic ord);
        beat_q_t q;
        beat_t   b;
        for (int k = 0; k < 8; k++) begin
            int r = ord ? 7 - k : k;
            b.data = v[r];
            b.idx  = 3'(r);
            b.last = (k == 7);
            q.push_back(b);
        end
        return q;
    endfunction

    // A frame is in order exactly when it equals its own sorted copy.
    function automatic logic model_err(input frame_t v);
        int s[$];
        for (int i = 0; i < 8; i++) s.push_back(int'(v[i]));
        s.sort();
        for (int i = 0; i < 8; i++) if (s[i] != int'(v[i])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic frame_t rand_frame(input bit sorted);
        frame_t v;
        int     s[$];
        for (int i = 0; i < 8; i++) s.push_back(int'($urandom_range(0, 15)));
        if (sorted) s.sort();
        for (int i = 0; i < 8; i++) v[i] = 4'(s[i]);
        return v;
    endfunction

    task automatic set_bus(input frame_t v);
        LT = v[0]; LO = v[1]; LM = v[2]; ME = v[3];
        MH = v[4]; HI = v[5]; HR = v[6]; HT = v[7];
    endtask

    // Drives a done rise; returns at the sample point of the first streaming cycle.
    task automatic launch(input frame_t v, input logic ord);
        set_bus(v);
        order = ord;
        done  = 1'b1;
        @(negedge clk);
    endtask

    // Consumes beats until out_valid drops. mode 0: ready high, 1: alternate from 0, 2: random.
    // The bus and order are scrambled every cycle to show they are only sampled at capture.
    task automatic drain(input int mode, output beat_q_t got, output int cycles, output int holds);
        beat_t prev;
        beat_t cur;
        logic  stalled;
        got     = {};
        cycles  = 0;
        holds   = 0;
        stalled = 1'b0;
        prev    = '0;
        for (int k = 0; k < 200; k++) begin
            if (!out_valid) break;
            cycles++;
            cur = {out_data, out_index, out_last};
            if (stalled && cur !== prev) holds++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((k % 2) == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            prev    = cur;
            stalled = !out_ready;
            if (out_ready) got.push_back(cur);
            set_bus(rand_frame(1'b0));
            order = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_index, out_last, busy, sort_err, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {out_valid, out_data, out_index, out_last, busy, sort_err, overrun});
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_done_held cycle %0d: valid=%b busy=%b required 0", k, out_valid, busy);
            end
        end
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_direction(input string name, input logic ord);
        frame_t  v = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd10, 4'd14, 4'd15};
        beat_q_t exp = model_frame(v, ord);
        beat_q_t got;
        int      cycles, holds;
        launch(v, ord);
        drain(0, got, cycles, holds);
        checks++;
        if (got.size() != exp.size() || cycles != 8) begin
            errors++;
            $display("FAIL %s_len: beats=%0d cycles=%0d required 8/8", name, got.size(), cycles);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s_beat%0d: got %h required %h", name, i, got[i], exp[i]);
            end
        end
        checks++;
        if (sort_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: sort_err=%b busy=%b required 0/0", name, sort_err, busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_no_refire: valid=%b required 0", name, out_valid);
            end
        end
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        frame_t  v = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd10, 4'd14, 4'd15};
        beat_q_t exp = model_frame(v, 1'b0);
        beat_q_t got;
        int      cycles, holds;
        launch(v, 1'b0);
        drain(1, got, cycles, holds);
        checks++;
        if (got.size() != 8 || cycles != 16 || holds != 0) begin
            errors++;
            $display("FAIL bp_shape: beats=%0d cycles=%0d holds=%0d required 8/16/0", got.size(), cycles, holds);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_order_error();
        frame_t  v = '{4'd7, 4'd1, 4'd0, 4'd15, 4'd5, 4'd10, 4'd14, 4'd6};
        beat_q_t exp = model_frame(v, 1'b0);
        beat_q_t got;
        int      cycles, holds;
        launch(v, 1'b0);
        checks++;
        if (sort_err !== 1'b1) begin
            errors++;
            $display("FAIL oerr_flag: got %b required 1", sort_err);
        end
        drain(0, got, cycles, holds);
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL oerr_len: got %0d required 8", got.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL oerr_beat%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (sort_err !== 1'b1) begin
            errors++;
            $display("FAIL oerr_held: got %b required 1", sort_err);
        end
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            frame_t  v   = rand_frame(1'($urandom_range(0, 1)));
            logic    ord = 1'($urandom_range(0, 1));
            beat_q_t exp = model_frame(v, ord);
            beat_q_t got;
            int      cycles, holds;
            launch(v, ord);
            checks++;
            if (sort_err !== model_err(v)) begin
                errors++;
                $display("FAIL rand%0d_sort_err: got %b required %b", f, sort_err, model_err(v));
            end
            drain(2, got, cycles, holds);
            checks++;
            if (got.size() != 8 || holds != 0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_shape: beats=%0d holds=%0d overrun=%b required 8/0/0",
                         f, got.size(), holds, overrun);
            end
            for (int i = 0; i < exp.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got %h required %h", f, i, got[i], exp[i]);
                end
            end
            done = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_overrun_chain();
        frame_t  v1 = rand_frame(1'b1);
        frame_t  v2 = rand_frame(1'b0);
        logic    o2 = 1'($urandom_range(0, 1));
        beat_q_t exp;
        beat_q_t got;
        exp = {model_frame(v1, 1'b0), model_frame(v2, o2)};
        launch(v1, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (!out_valid) break;
            got.push_back({out_data, out_index, out_last});
            if (k == 3 || k == 4) begin
                checks++;
                if (overrun !== (k == 4)) begin
                    errors++;
                    $display("FAIL ovr_flag_k%0d: got %b required %b", k, overrun, k == 4);
                end
            end
            if (k < 7) begin
                set_bus(rand_frame(1'b0));
                order = 1'($urandom_range(0, 1));
            end else if (k == 7) begin
                set_bus(v2);
                order = o2;
            end
            if (k == 2 || k == 5) done = 1'b0;
            if (k == 3 || k == 7) done = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (got.size() != 16 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_len: beats=%0d valid_after=%b required 16/0", got.size(), out_valid);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL ovr_beat%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (overrun !== 1'b1 || sort_err !== model_err(v2)) begin
            errors++;
            $display("FAIL ovr_final: overrun=%b sort_err=%b required 1/%b", overrun, sort_err, model_err(v2));
        end
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        launch(rand_frame(1'b0), 1'b0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd4) begin
            errors++;
            $display("FAIL mid_pre: valid=%b index=%0d required 1/4", out_valid, out_index);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_index, out_last, busy, sort_err, overrun} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b required 0",
                     {out_valid, out_data, out_index, out_last, busy, sort_err, overrun});
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_frame cycle %0d: valid=%b required 0", k, out_valid);
            end
        end
        out_ready = 1'b0;
        done      = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        done      = 1'b1;
        order     = 1'b0;
        out_ready = 1'b0;
        set_bus('{default: 4'd0});
        test_reset();
        test_direction("asc", 1'b0);
        test_direction("desc", 1'b1);
        test_backpressure();
        test_order_error();
        test_random();
        test_overrun_chain();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sorted_streamer.md
# sorted_streamer

Reader for the `sorter` result bus. On each new assertion of `done` it snapshots the eight sorted 4-bit outputs (`LT` through `HT`) into a local buffer. It then streams them out one value per accepted beat over a valid/ready handshake, in ascending or descending order. It also reports whether the captured frame was actually non-decreasing, and flags frames lost while busy. It sits directly downstream of `sorter` and decouples the sorter from a slower consumer.

## Interface
Parameters:
- `WIDTH`, 4, bits per value.
- `COUNT`, 8, values per frame. Fixed at 8 to match the `sorter` bus; `out_index` is 3 bits.

Ports:
- `clk`, in, 1, single clock, rising edge.
- `rst`, in, 1, reset. Synchronous, active-high.
- `done`, in, 1, sorter result-valid level. May stay high for many cycles.
- `LT`, `LO`, `LM`, `ME`, `MH`, `HI`, `HR`, `HT`, in, WIDTH each, sorter outputs, rank 0 (lowest) to rank 7.
- `order`, in, 1, direction, sampled at capture only. 0 = ascending (`LT` first); 1 = descending (`HT` first).
- `out_ready`, in, 1, consumer accepts the current beat.
- `out_valid`, out, 1, beat present.
- `out_data`, out, WIDTH, value of the current beat.
- `out_index`, out, 3, rank (0..7) of `out_data` in the sorter bus.
- `out_last`, out, 1, current beat is the final beat of the frame.
- `busy`, out, 1, high while in STREAM.
- `sort_err`, out, 1, captured frame was not non-decreasing. Held until the next capture.
- `overrun`, out, 1, sticky. A `done` rise was dropped. Cleared only by `rst`.

## Operation
Rise detection:
- `done_q` is a register of `done`.
- `rise = done & ~done_q`.
- `done_q` resets to 1, so a `done` held high through reset is not treated as a new frame.

States: IDLE and STREAM.

IDLE:
- `out_valid` = 0.
- On `rise`: load the buffer with all eight inputs, latch `order`, compute and latch `sort_err`, set `cnt` = 0, go to STREAM.

STREAM:
- `out_valid` = 1.
- `out_index` = `cnt` when the latched order is 0, or 7 − `cnt` when it is 1.
- `out_data` = buffer[`out_index`].
- `out_last` = (`cnt` == 7).
- A beat completes when `out_valid & out_ready`. On completion `cnt` increments; while `out_ready` is low, all outputs hold steady.
- When the beat with `out_last` completes, go to IDLE.
- Exception: if `rise` occurs in that same cycle, capture the new frame and stay in STREAM with `cnt` = 0. This is not an overrun.

Overrun:
- `rise` in STREAM at any other time is ignored. The buffer is unchanged and `overrun` is set to 1.

Order check:
- `sort_err` = 1 if any adjacent pair violates rank[i] <= rank[i+1], compared as unsigned.
- Equal values are legal.
- Frame data is streamed regardless of `sort_err`.

Reset values: `out_valid`, `out_data`, `out_index`, `out_last`, `busy`, `sort_err`, `overrun` all 0. State = IDLE, `cnt` = 0.

Reset mid-stream aborts the frame. No further beats are emitted until a new `rise`.

## Timing
- `rise` sampled at edge N: `out_valid` is first high in cycle N+1, and the first beat can complete at edge N+1.
- With `out_ready` held high, the frame takes exactly 8 cycles, N+1 through N+8, and `busy` falls after edge N+8.
- Back-to-back frames are possible with no bubble, through the final-beat capture rule.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `out_ready` to any output.
- `LT`..`HT` and `order` are sampled only in the capture cycle. Later changes have no effect on the frame in flight.

## Structure
- Shared package `sorter_pkg`: `WIDTH` and `COUNT` constants, the state encoding (IDLE, STREAM), and the index width. The same package is used by `sorter`.
- Sub-module `sort_order_check`: purely combinational. Takes the eight values and returns the `sort_err` bit.
- Buffer and counter live in `sorted_streamer`.

## Test plan
- **Ascending:** LT..HT = 0,1,5,6,7,10,14,15; `order`=0; `done` rises and stays high; `out_ready`=1. Expect data 0,1,5,6,7,10,14,15 and index 0..7 on cycles N+1..N+8; `out_last` only on 15; `sort_err`=0; `done` staying high causes no second frame.
- **Descending:** same data, `order`=1. Expect 15,14,10,7,6,5,1,0, index 7..0, `out_last` on value 0.
- **Backpressure:** `out_ready` alternates 1/0 starting at 0. Each value is held while not ready; the frame completes in 16 cycles with the same sequence and no duplicates or drops.
- **Overrun and chaining:**
  - Toggle `done` low then high at beat 3: `overrun`=1, stream unchanged.
  - Then raise `done` exactly on the final accepted beat: the new frame starts the next cycle, and `overrun` stays 1 from the earlier event only.
- **Order error:** LT..HT = 7,1,0,15,5,10,14,6. Expect `sort_err`=1; beats stream 7,1,0,15,5,10,14,6 in ascending rank order.
- **Reset:**
  - Assert `rst` at beat 4: next cycle all outputs are 0 and state is IDLE.
  - Hold `done` high through and after reset: no frame is emitted.
